// File: rtl/vga_pkg.sv
// Shared VGA timing constants and counter types, reused by the timing
// generator, the draw_* overlay stages and the benches.
package vga_pkg;

   localparam int CNT_W = 11;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      int active;
      int sync_start;
      int sync_len;
      int total;
   } axis_timing_t;

   // 800x600 @ 60 Hz, 40 MHz pixel clock
   localparam axis_timing_t SVGA_H = '{active: 800, sync_start: 840, sync_len: 128, total: 1056};
   localparam axis_timing_t SVGA_V = '{active: 600, sync_start: 601, sync_len: 4,   total: 628};

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam axis_timing_t VGA_H  = '{active: 640, sync_start: 656, sync_len: 96,  total: 800};
   localparam axis_timing_t VGA_V  = '{active: 480, sync_start: 490, sync_len: 2,   total: 525};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing stream between the generator (master) and the draw_* stages (slave).
interface vga_timing_gen_if;
   import vga_pkg::*;

   logic en;
   cnt_t hcount_out;
   cnt_t vcount_out;
   logic hsync_out;
   logic vsync_out;
   logic hblnk_out;
   logic vblnk_out;
   logic line_start;
   logic frame_start;

   modport master (
      input  en,
      output hcount_out, vcount_out, hsync_out, vsync_out,
             hblnk_out, vblnk_out, line_start, frame_start
   );

   modport slave (
      output en,
      input  hcount_out, vcount_out, hsync_out, vsync_out,
             hblnk_out, vblnk_out, line_start, frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with blank and sync flags
// registered from the next count, so flags line up with the presented count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL      = SVGA_H.total,
   parameter int ACTIVE     = SVGA_H.active,
   parameter int SYNC_START = SVGA_H.sync_start,
   parameter int SYNC_LEN   = SVGA_H.sync_len,
   parameter bit POL        = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   output cnt_t cnt,
   output logic wrap,
   output logic blnk,
   output logic sync
);

   if (TOTAL > (1 << CNT_W) || ACTIVE < 1 || ACTIVE >= SYNC_START ||
       SYNC_LEN < 1 || SYNC_START + SYNC_LEN > TOTAL) begin : g_bad_params
      $error("vga_axis_counter: illegal timing parameters");
   end

   localparam cnt_t             LAST = cnt_t'(TOTAL - 1);
   localparam cnt_t             ACT  = cnt_t'(ACTIVE);
   localparam logic [CNT_W:0]   S0   = (CNT_W + 1)'(SYNC_START);
   localparam logic [CNT_W:0]   S1   = (CNT_W + 1)'(SYNC_START + SYNC_LEN);

   cnt_t           nxt;
   logic [CNT_W:0] nxt_w;
   logic           in_sync;

   // 12-bit compare so a sync window ending exactly at 2048 still fits
   assign nxt     = (cnt == LAST) ? '0 : cnt + 1'b1;
   assign nxt_w   = {1'b0, nxt};
   assign in_sync = (nxt_w >= S0) && (nxt_w < S1);
   assign wrap    = inc && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         blnk <= 1'b0;
         sync <= ~POL;
      end else if (inc) begin
         cnt  <= nxt;
         blnk <= (nxt >= ACT);
         sync <= in_sync ? POL : ~POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing source: h/v axis counters plus line/frame strobes.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE     = SVGA_H.active,
   parameter int H_SYNC_START = SVGA_H.sync_start,
   parameter int H_SYNC_LEN   = SVGA_H.sync_len,
   parameter int H_TOTAL      = SVGA_H.total,
   parameter int V_ACTIVE     = SVGA_V.active,
   parameter int V_SYNC_START = SVGA_V.sync_start,
   parameter int V_SYNC_LEN   = SVGA_V.sync_len,
   parameter int V_TOTAL      = SVGA_V.total,
   parameter bit HS_POL       = 1'b1,
   parameter bit VS_POL       = 1'b1
) (
   input  logic              pclk,
   input  logic              rst,
   vga_timing_gen_if.master  vga
);

   logic started;
   logic first;
   logic h_inc;
   logic h_wrap;
   logic v_wrap;

   // The first enabled cycle after reset presents (0,0) with both strobes;
   // counting proper starts on the following edge.
   assign first = vga.en & ~started;
   assign h_inc = vga.en & started;

   vga_axis_counter #(
      .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_SYNC_START),
      .SYNC_LEN(H_SYNC_LEN), .POL(HS_POL)
   ) u_h (
      .clk(pclk), .rst(rst), .inc(h_inc),
      .cnt(vga.hcount_out), .wrap(h_wrap), .blnk(vga.hblnk_out), .sync(vga.hsync_out)
   );

   vga_axis_counter #(
      .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_SYNC_START),
      .SYNC_LEN(V_SYNC_LEN), .POL(VS_POL)
   ) u_v (
      .clk(pclk), .rst(rst), .inc(h_wrap),
      .cnt(vga.vcount_out), .wrap(v_wrap), .blnk(vga.vblnk_out), .sync(vga.vsync_out)
   );

   always_ff @(posedge pclk) begin
      if (rst) begin
         started         <= 1'b0;
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
      end else if (vga.en) begin
         started         <= 1'b1;
         vga.line_start  <= h_wrap | first;
         vga.frame_start <= v_wrap | first;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: SVGA, 640x480 negative-polarity and a tiny-geometry instance.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam axis_timing_t TH = '{active: 8, sync_start: 10, sync_len: 3, total: 16};
  localparam axis_timing_t TV = '{active: 4, sync_start: 5,  sync_len: 2, total: 8};

  typedef struct { int hc; int vc; bit hs; bit vs; bit hb; bit vb; bit ls; bit fs; } obs_t;
  typedef struct { int dut; int adv; obs_t exp; } vec_t;

  logic pclk = 1'b0;
  logic rst_s, rst_v, rst_t;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];

  always #5 pclk = ~pclk;

  vga_timing_gen_if if_s();
  vga_timing_gen_if if_v();
  vga_timing_gen_if if_t();

  vga_timing_gen u_svga (.pclk(pclk), .rst(rst_s), .vga(if_s));

  vga_timing_gen #(
    .H_ACTIVE(VGA_H.active), .H_SYNC_START(VGA_H.sync_start),
    .H_SYNC_LEN(VGA_H.sync_len), .H_TOTAL(VGA_H.total),
    .V_ACTIVE(VGA_V.active), .V_SYNC_START(VGA_V.sync_start),
    .V_SYNC_LEN(VGA_V.sync_len), .V_TOTAL(VGA_V.total),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_vga (.pclk(pclk), .rst(rst_v), .vga(if_v));

  vga_timing_gen #(
    .H_ACTIVE(TH.active), .H_SYNC_START(TH.sync_start),
    .H_SYNC_LEN(TH.sync_len), .H_TOTAL(TH.total),
    .V_ACTIVE(TV.active), .V_SYNC_START(TV.sync_start),
    .V_SYNC_LEN(TV.sync_len), .V_TOTAL(TV.total)
  ) u_tiny (.pclk(pclk), .rst(rst_t), .vga(if_t));

  function automatic obs_t mk(int hc, int vc, bit hs, bit vs, bit hb, bit vb, bit ls, bit fs);
    obs_t o;
    o.hc = hc; o.vc = vc; o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic obs_t get(int d);
    case (d)
      0: return mk(int'(if_s.hcount_out), int'(if_s.vcount_out), if_s.hsync_out, if_s.vsync_out,
                   if_s.hblnk_out, if_s.vblnk_out, if_s.line_start, if_s.frame_start);
      1: return mk(int'(if_v.hcount_out), int'(if_v.vcount_out), if_v.hsync_out, if_v.vsync_out,
                   if_v.hblnk_out, if_v.vblnk_out, if_v.line_start, if_v.frame_start);
      default: return mk(int'(if_t.hcount_out), int'(if_t.vcount_out), if_t.hsync_out, if_t.vsync_out,
                   if_t.hblnk_out, if_t.vblnk_out, if_t.line_start, if_t.frame_start);
    endcase
  endfunction

  task automatic add(int dut, int adv, obs_t e);
    vec_t v;
    v.dut = dut; v.adv = adv; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_obs(string nm, obs_t g, obs_t e);
    chk({nm, ".hcount"}, g.hc, e.hc);
    chk({nm, ".vcount"}, g.vc, e.vc);
    chk({nm, ".hsync"}, int'(g.hs), int'(e.hs));
    chk({nm, ".vsync"}, int'(g.vs), int'(e.vs));
    chk({nm, ".hblnk"}, int'(g.hb), int'(e.hb));
    chk({nm, ".vblnk"}, int'(g.vb), int'(e.vb));
    chk({nm, ".line_start"}, int'(g.ls), int'(e.ls));
    chk({nm, ".frame_start"}, int'(g.fs), int'(e.fs));
  endtask

  task automatic run_tbl(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      repeat (tbl[i].adv) @(negedge pclk);
      chk_obs($sformatf("vec%0d", i), get(tbl[i].dut), tbl[i].exp);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s_vga, s_tiny, s_end;
    int n_hs, n_vs, n_hb, n_vb, n_ls, n_fs, fs_at;
    obs_t frozen;

    rst_s = 1'b1; rst_v = 1'b1; rst_t = 1'b1;
    if_s.en = 1'b1; if_v.en = 1'b1; if_t.en = 1'b1;

    // SVGA: one full line plus the wrap into line 1
    add(0, 1,   mk(0,    0, 0, 0, 0, 0, 1, 1));
    add(0, 1,   mk(1,    0, 0, 0, 0, 0, 0, 0));
    add(0, 798, mk(799,  0, 0, 0, 0, 0, 0, 0));
    add(0, 1,   mk(800,  0, 0, 0, 1, 0, 0, 0));
    add(0, 39,  mk(839,  0, 0, 0, 1, 0, 0, 0));
    add(0, 1,   mk(840,  0, 1, 0, 1, 0, 0, 0));
    add(0, 127, mk(967,  0, 1, 0, 1, 0, 0, 0));
    add(0, 1,   mk(968,  0, 0, 0, 1, 0, 0, 0));
    add(0, 87,  mk(1055, 0, 0, 0, 1, 0, 0, 0));
    add(0, 1,   mk(0,    1, 0, 0, 0, 0, 1, 0));
    add(0, 1,   mk(1,    1, 0, 0, 0, 0, 0, 0));
    s_vga = tbl.size();
    // 640x480, active-low syncs
    add(1, 1,   mk(0,   0, 1, 1, 0, 0, 1, 1));
    add(1, 639, mk(639, 0, 1, 1, 0, 0, 0, 0));
    add(1, 1,   mk(640, 0, 1, 1, 1, 0, 0, 0));
    add(1, 16,  mk(656, 0, 0, 1, 1, 0, 0, 0));
    add(1, 95,  mk(751, 0, 0, 1, 1, 0, 0, 0));
    add(1, 1,   mk(752, 0, 1, 1, 1, 0, 0, 0));
    s_tiny = tbl.size();
    // tiny geometry: whole frame including vertical windows and wrap
    add(2, 1,  mk(0,  0, 0, 0, 0, 0, 1, 1));
    add(2, 8,  mk(8,  0, 0, 0, 1, 0, 0, 0));
    add(2, 2,  mk(10, 0, 1, 0, 1, 0, 0, 0));
    add(2, 3,  mk(13, 0, 0, 0, 1, 0, 0, 0));
    add(2, 2,  mk(15, 0, 0, 0, 1, 0, 0, 0));
    add(2, 1,  mk(0,  1, 0, 0, 0, 0, 1, 0));
    add(2, 48, mk(0,  4, 0, 0, 0, 1, 1, 0));
    add(2, 16, mk(0,  5, 0, 1, 0, 1, 1, 0));
    add(2, 15, mk(15, 5, 0, 1, 1, 1, 0, 0));
    add(2, 1,  mk(0,  6, 0, 1, 0, 1, 1, 0));
    add(2, 16, mk(0,  7, 0, 0, 0, 1, 1, 0));
    add(2, 15, mk(15, 7, 0, 0, 1, 1, 0, 0));
    add(2, 1,  mk(0,  0, 0, 0, 0, 0, 1, 1));
    s_end = tbl.size();

    // Reset held with en=1: reset wins
    repeat (5) @(negedge pclk);
    chk_obs("rst_svga", get(0), mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk_obs("rst_vga",  get(1), mk(0, 0, 1, 1, 0, 0, 0, 0));
    chk_obs("rst_tiny", get(2), mk(0, 0, 0, 0, 0, 0, 0, 0));

    rst_s = 1'b0;
    run_tbl(0, s_vga);

    // SVGA line statistics from (1,1) across one full line
    n_hs = 0; n_hb = 0; n_ls = 0;
    for (int i = 0; i < 1056; i++) begin
      @(negedge pclk);
      n_hs += int'(if_s.hsync_out);
      n_hb += int'(if_s.hblnk_out);
      n_ls += int'(if_s.line_start);
    end
    chk("svga_hsync_cycles", n_hs, 128);
    chk("svga_hblnk_cycles", n_hb, 256);
    chk("svga_line_starts", n_ls, 1);
    chk("svga_line_end_hcount", int'(if_s.hcount_out), 1);
    chk("svga_line_end_vcount", int'(if_s.vcount_out), 2);

    rst_v = 1'b0;
    run_tbl(s_vga, s_tiny);

    rst_t = 1'b0;
    run_tbl(s_tiny, s_end);

    // Tiny: one full frame from (0,0)
    n_hs = 0; n_vs = 0; n_hb = 0; n_vb = 0; n_ls = 0; n_fs = 0; fs_at = -1;
    for (int i = 1; i <= 128; i++) begin
      @(negedge pclk);
      n_hs += int'(if_t.hsync_out);
      n_vs += int'(if_t.vsync_out);
      n_hb += int'(if_t.hblnk_out);
      n_vb += int'(if_t.vblnk_out);
      n_ls += int'(if_t.line_start);
      n_fs += int'(if_t.frame_start);
      if (if_t.frame_start) fs_at = i;
    end
    chk("tiny_hsync_cycles", n_hs, 24);
    chk("tiny_vsync_cycles", n_vs, 32);
    chk("tiny_hblnk_cycles", n_hb, 64);
    chk("tiny_vblnk_cycles", n_vb, 64);
    chk("tiny_line_starts", n_ls, 8);
    chk("tiny_frame_starts", n_fs, 1);
    chk("tiny_frame_period", fs_at, 128);

    // Freeze at the last pixel of the frame
    repeat (127) @(negedge pclk);
    frozen = mk(15, 7, 0, 0, 1, 1, 0, 0);
    chk_obs("pre_freeze", get(2), frozen);
    if_t.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      chk_obs($sformatf("freeze%0d", i), get(2), frozen);
    end
    if_t.en = 1'b1;
    @(negedge pclk);
    chk_obs("resume", get(2), mk(0, 0, 0, 0, 0, 0, 1, 1));
    if_t.en = 1'b0;
    repeat (3) @(negedge pclk);
    chk_obs("strobe_hold", get(2), mk(0, 0, 0, 0, 0, 0, 1, 1));
    if_t.en = 1'b1;
    @(negedge pclk);
    chk_obs("strobe_once", get(2), mk(1, 0, 0, 0, 0, 0, 0, 0));

    // Reset while both syncs are active
    repeat (90) @(negedge pclk);
    chk_obs("in_sync", get(2), mk(11, 5, 1, 1, 1, 1, 0, 0));
    rst_t = 1'b1;
    @(negedge pclk);
    chk_obs("mid_rst", get(2), mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_t = 1'b0;
    @(negedge pclk);
    chk_obs("post_rst0", get(2), mk(0, 0, 0, 0, 0, 0, 1, 1));
    @(negedge pclk);
    chk_obs("post_rst1", get(2), mk(1, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
